// File: rtl/jts16_tmap_pkg.sv
// jts16_tmap_pkg: shared constants and types for the tilemap SDRAM read arbiter
package jts16_tmap_pkg;
    localparam int REQ_CHAR = 0;
    localparam int REQ_MAP1 = 1;
    localparam int REQ_SCR1 = 2;
    localparam int REQ_MAP2 = 3;
    localparam int REQ_SCR2 = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // successor of idx on a ring of n requesters
    function automatic int ring_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/jts16_tmap_slot.sv
// jts16_tmap_slot: one-entry tag/data cache serving a single tilemap requester
module jts16_tmap_slot #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          load_tag,
    input  logic          fill,
    input  logic          inval,
    input  logic [31:0]   din,
    output logic          ok,
    output logic [31:0]   data
);
    logic [AW-1:0] tag_q, tag_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;

    always_comb begin
        tag_d   = load_tag ? addr : tag_q;
        // a fill carries fresh data, so it beats a coincident invalidate
        valid_d = fill ? 1'b1 : (load_tag || inval) ? 1'b0 : valid_q;
        data_d  = fill ? din : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ok   = cs && valid_q && tag_q == addr;
    assign data = data_q;
endmodule

// File: rtl/jts16_tmap_arb.sv
// jts16_tmap_arb: shares one SDRAM read port among five tilemap requesters,
// each fronted by a one-entry cache; misses are granted round-robin.
module jts16_tmap_arb
    import jts16_tmap_pkg::*;
#(
    parameter int AW   = 22,
    parameter int NREQ = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inval,
    input  logic [NREQ-1:0]    req_cs,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ok,
    output logic [NREQ*32-1:0] req_data,
    output logic               sdram_req,
    output logic [AW-1:0]      sdram_addr,
    input  logic               sdram_ack,
    input  logic               sdram_rdy,
    input  logic [31:0]        sdram_din,
    output logic               busy
);
    localparam int GW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, rr_q, rr_d, pick;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            load, fill;
    logic [NREQ-1:0] miss;

    assign miss = req_cs & ~req_ok;

    // walk the ring backwards so the nearest miss after rr is the last one written
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (miss[ring_next(int'(rr_q) + k, NREQ)]) pick = GW'(ring_next(int'(rr_q) + k, NREQ));
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        load    = 1'b0;
        fill    = 1'b0;
        case (state_q)
            ST_IDLE: if (|miss) begin
                gnt_d   = pick;
                addr_d  = req_addr[pick*AW +: AW];
                load    = 1'b1;
                req_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: if (sdram_ack) begin
                req_d   = 1'b0;
                rr_d    = gnt_q;
                fill    = sdram_rdy;
                state_d = sdram_rdy ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (sdram_rdy) begin
                fill    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        jts16_tmap_slot #(.AW(AW)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .cs       (req_cs[g]),
            .addr     (req_addr[g*AW +: AW]),
            .load_tag (load && pick == GW'(g)),
            .fill     (fill && gnt_q == GW'(g)),
            .inval    (inval),
            .din      (sdram_din),
            .ok       (req_ok[g]),
            .data     (req_data[g*32 +: 32])
        );
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign busy       = state_q != ST_IDLE;
endmodule

// File: tb/tb_jts16_tmap_arb.sv
// tb_jts16_tmap_arb: directed vectors, corner sequences and a randomized run
// against a behavioural cache/arbiter reference model.
module tb_jts16_tmap_arb;
    localparam int AW   = 22;
    localparam int NREQ = 5;

    logic               clk = 1'b0, rst_n = 1'b1, inval = 1'b0;
    logic [NREQ-1:0]    req_cs = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]    req_ok;
    logic [NREQ*32-1:0] req_data;
    logic               sdram_req;
    logic [AW-1:0]      sdram_addr;
    logic               sdram_ack = 1'b0, sdram_rdy = 1'b0;
    logic [31:0]        sdram_din = '0;
    logic               busy;

    int checks = 0, failures = 0;

    int            mph = 0;
    logic [AW-1:0] maddr = '0;
    logic [AW-1:0] grants[$];
    int            order[NREQ] = '{1, 2, 3, 4, 0};

    logic [AW-1:0]   mtag[NREQ];
    logic [31:0]     mdata[NREQ];
    logic [NREQ-1:0] mv, eok, mm;
    int              mp, mrr, mg, kk;
    logic            ra, rd, fillm;

    typedef struct {
        int            idx;
        logic [AW-1:0] addr;
        logic [31:0]   din;
        int            a;
        int            r;
        int            ok_at;
    } vec_t;
    vec_t tv[4];

    jts16_tmap_arb #(.AW(AW), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inval      (inval),
        .req_cs     (req_cs),
        .req_addr   (req_addr),
        .req_ok     (req_ok),
        .req_data   (req_data),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic r, input logic [31:0] d);
        sdram_ack = a;
        sdram_rdy = r;
        sdram_din = d;
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] get_addr(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [31:0] get_data(input int i);
        return req_data[i*32 +: 32];
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        req_cs = '0;
        inval  = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        mph   = 0;
        grants.delete();
    endtask

    // SDRAM responder: ack as soon as a request is seen, data on the next cycle
    task automatic mem_step();
        if (mph == 1) begin
            mph = 0;
            drive(1'b0, 1'b1, {10'h2A5, maddr});
        end else if (sdram_req) begin
            maddr = sdram_addr;
            grants.push_back(sdram_addr);
            mph = 1;
            drive(1'b1, 1'b0, 32'h0);
        end else begin
            drive(1'b0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        tv[0] = '{2, 22'h01234, 32'hDEADBEEF, 1, 3, 4};
        tv[1] = '{0, 22'h3FFFFF, 32'h00000000, 1, 2, 3};
        tv[2] = '{4, 22'h000000, 32'hFFFFFFFF, 1, 1, 2};
        tv[3] = '{1, 22'h02AAAA, 32'h12345678, 3, 6, 7};

        // reset state, with every requester asking for address 0 (matches the reset tag)
        #1 rst_n = 1'b0;
        req_cs = '1;
        #2;
        chk("rst_sdram_req", sdram_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sdram_addr", sdram_addr, '0);
        chk("rst_ok", req_ok, '0);
        tick();
        tick();
        req_cs = '0;
        rst_n  = 1'b1;

        // single-requester fetches with assorted ack/rdy timing, then a repeat hit
        foreach (tv[v]) begin
            req_cs = '0;
            set_addr(tv[v].idx, tv[v].addr);
            req_cs[tv[v].idx] = 1'b1;
            for (int c = 0; c <= tv[v].ok_at; c++) begin
                drive(c == tv[v].a, c == tv[v].r, c == tv[v].r ? tv[v].din : 32'h0BAD0BAD);
                chk("vec_req", sdram_req, c >= 1 && c <= tv[v].a);
                chk("vec_busy", busy, c >= 1 && c <= tv[v].r);
                chk("vec_ok", req_ok[tv[v].idx], c == tv[v].ok_at);
                if (c == 1) chk("vec_addr", sdram_addr, tv[v].addr);
                if (c == tv[v].ok_at) chk("vec_data", get_data(tv[v].idx), tv[v].din);
                tick();
            end
            drive(1'b0, 1'b0, 32'h0);
            chk("vec_hit_ok", req_ok[tv[v].idx], 1'b1);
            chk("vec_hit_noreq", sdram_req, 1'b0);
            tick();
        end
        req_cs = '0;

        // all five miss together right after reset: grants 1,2,3,4,0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(32'h100 + i));
        req_cs = '1;
        for (int c = 0; c < 40 && req_ok != '1; c++) begin
            mem_step();
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("rr_all_ok", req_ok, 5'h1F);
        tick();
        tick();
        chk("rr_access_count", grants.size(), 5);
        for (int k = 0; k < NREQ; k++) begin
            if (k < grants.size()) chk("rr_order", grants[k], AW'(32'h100 + order[k]));
            chk("rr_data", get_data(k), {10'h2A5, get_addr(k)});
        end

        // requester 0 moves its address while the fetch is in DATA
        req_cs = '0;
        set_addr(0, 22'h10);
        req_cs[0] = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        chk("chg_addr", sdram_addr, 22'h10);
        tick();
        set_addr(0, 22'h11);
        drive(1'b0, 1'b0, 32'h0);
        chk("chg_busy", busy, 1'b1);
        chk("chg_ok_during", req_ok[0], 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h10101010);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("chg_stale_ok", req_ok[0], 1'b0);
        chk("chg_idle", busy, 1'b0);
        set_addr(0, 22'h10);
        #1;
        chk("chg_old_tag_ok", req_ok[0], 1'b1);
        chk("chg_old_tag_data", get_data(0), 32'h10101010);
        set_addr(0, 22'h11);
        tick();
        drive(1'b1, 1'b1, 32'h11111111);
        chk("chg_reissue_req", sdram_req, 1'b1);
        chk("chg_reissue_addr", sdram_addr, 22'h11);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("chg_new_ok", req_ok[0], 1'b1);
        chk("chg_new_data", get_data(0), 32'h11111111);
        tick();

        // inval coinciding with the fill: the filled slot survives, hits re-fetch
        req_cs = '0;
        set_addr(3, 22'h300);
        req_cs[0] = 1'b1;
        req_cs[1] = 1'b1;
        req_cs[3] = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        chk("inv_pre_ok", req_ok, 5'b00011);
        tick();
        drive(1'b1, 1'b0, 32'h0);
        tick();
        inval = 1'b1;
        drive(1'b0, 1'b1, 32'h33333333);
        tick();
        inval = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("inv_ok", req_ok, 5'b01000);
        chk("inv_req_idle", sdram_req, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h00000011);
        chk("inv_refetch_req", sdram_req, 1'b1);
        chk("inv_refetch0_addr", sdram_addr, 22'h11);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("inv_ok_after0", req_ok, 5'b01001);
        chk("inv_fill_data", get_data(3), 32'h33333333);
        tick();
        drive(1'b1, 1'b1, 32'h00000101);
        chk("inv_refetch1_addr", sdram_addr, 22'h101);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("inv_ok_after1", req_ok, 5'b01011);
        tick();

        // asynchronous reset while waiting for ack, then a stray rdy
        req_cs = '0;
        set_addr(2, 22'h555);
        req_cs[2] = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("arst_pre_req", sdram_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", sdram_req, 1'b0);
        chk("arst_busy", busy, 1'b0);
        req_cs = '0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'hBADBAD00);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        req_cs   = '1;
        req_addr = '0;
        #1;
        chk("stray_ok", req_ok, '0);
        chk("stray_busy", busy, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        mv  = '0;
        mp  = 0;
        mrr = 0;
        mg  = 0;
        for (int i = 0; i < NREQ; i++) begin
            mtag[i]  = '0;
            mdata[i] = '0;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(7) == 0) req_cs[i] = ~req_cs[i];
                if ($urandom_range(5) == 0) set_addr(i, AW'(i * 16 + $urandom_range(3)));
            end
            inval = $urandom_range(31) == 0;
            ra = mp == 1 && $urandom_range(1) == 1;
            rd = (mp == 2 && $urandom_range(1) == 1) || (ra && $urandom_range(3) == 0) ||
                 (mp == 0 && $urandom_range(15) == 0);
            drive(ra, rd, $urandom);
            for (int i = 0; i < NREQ; i++) eok[i] = req_cs[i] && mv[i] && mtag[i] == get_addr(i);
            chk("rnd_ok", req_ok, eok);
            for (int i = 0; i < NREQ; i++) if (eok[i]) chk("rnd_data", get_data(i), mdata[i]);
            chk("rnd_req", sdram_req, mp == 1);
            chk("rnd_busy", busy, mp != 0);
            if (mp == 1) chk("rnd_addr", sdram_addr, mtag[mg]);
            mm    = req_cs & ~eok;
            fillm = 1'b0;
            if (mp == 0 && mm != '0) begin
                kk = 1;
                while (!mm[(mrr + kk) % NREQ]) kk++;
                mg       = (mrr + kk) % NREQ;
                mtag[mg] = get_addr(mg);
                mv[mg]   = 1'b0;
                mp       = 1;
            end else if (mp == 1 && sdram_ack) begin
                mrr   = mg;
                fillm = sdram_rdy;
                mp    = sdram_rdy ? 0 : 2;
            end else if (mp == 2 && sdram_rdy) begin
                fillm = 1'b1;
                mp    = 0;
            end
            if (inval) mv = '0;
            if (fillm) begin
                mv[mg]    = 1'b1;
                mdata[mg] = sdram_din;
            end
            tick();
        end
        inval  = 1'b0;
        req_cs = '0;
        drive(1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
